// File: rtl/dcache_wr_buffer_if.sv
// Purpose: dcache write-back request, miss-check and AXI3 write channel bundle.
// Latency: wires only, no state.
// Backpressure: carries wr_rdy and the AXI valid/ready pairs between the two sides.
interface dcache_wr_buffer_if;
  // dcache side
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         empty;
  // AXI write address
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [3:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [1:0]   awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  // AXI write data
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  // AXI write response
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  // The write buffer itself
  modport master (
    input  wr_req, wr_addr, wr_data, chk_addr,
    output wr_rdy, chk_hit, empty,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  // The dcache plus the AXI interconnect
  modport slave (
    output wr_req, wr_addr, wr_data, chk_addr,
    input  wr_rdy, chk_hit, empty,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dcache_wr_buffer.sv
// Purpose: buffers dcache line write-backs and drains them as 4-beat AXI3 INCR bursts.
// Latency: line pushed in cycle N shows awvalid in cycle N+2 when idle.
// Backpressure: wr_rdy drops when DEPTH lines are held; AXI stalls hold the head line.
module dcache_wr_buffer #(
  parameter int         DEPTH  = 2,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input logic             clk,
  input logic             reset,
  dcache_wr_buffer_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [1:0]     beat;
  logic [31:0]    addr_mem [DEPTH];
  logic [127:0]   data_mem [DEPTH];

  logic           rdy;
  logic           push;
  logic           pop;
  logic           aw_vld;
  logic           w_vld;
  logic           b_rdy;
  logic           hit;
  logic [PW-1:0]  off;

  // Response id/status and the sub-line address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.bid, bus.bresp, bus.wr_addr[3:0], bus.chk_addr[3:0]};

  // Acceptance depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign rdy  = (count != FULL_CNT);
  assign push = bus.wr_req & rdy;
  assign pop  = (state == B) & bus.bvalid;

  // Line storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= {bus.wr_addr[31:4], 4'b0000};
      data_mem[tail] <= bus.wr_data;
    end
  end

  // Circular pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Burst state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and channel handshakes for the head line's burst.
  always_comb begin
    state_nxt = state;
    aw_vld    = 1'b0;
    w_vld     = 1'b0;
    b_rdy     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = AW;
      end
      AW: begin
        aw_vld = 1'b1;
        if (bus.awready) state_nxt = W;
      end
      W: begin
        w_vld = 1'b1;
        if (bus.wready && (beat == 2'd3)) state_nxt = B;
      end
      B: begin
        b_rdy = 1'b1;
        if (bus.bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat index within the data burst; restarts whenever a new address is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat <= 2'd0;
    end else if ((state == AW) && bus.awready) begin
      beat <= 2'd0;
    end else if ((state == W) && bus.wready) begin
      beat <= beat + 2'd1;
    end
  end

  // Miss-address hazard: any held line, including the head still awaiting its response.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ((CW'(off) < count) && (addr_mem[i][31:4] == bus.chk_addr[31:4])) hit = 1'b1;
    end
  end

  assign bus.wr_rdy  = rdy;
  assign bus.chk_hit = hit;
  assign bus.empty   = (count == '0) && (state == IDLE);

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_mem[head];
  assign bus.awlen   = 4'd3;
  assign bus.awsize  = 3'd2;
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = aw_vld;

  assign bus.wid     = AXI_ID;
  assign bus.wdata   = data_mem[head][{beat, 5'b00000} +: 32];
  assign bus.wstrb   = 4'b1111;
  assign bus.wlast   = w_vld && (beat == 2'd3);
  assign bus.wvalid  = w_vld;

  assign bus.bready  = b_rdy;

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Purpose: checks the write buffer against a line-queue model plus directed literal expectations.
// Latency: monitor samples on the falling edge; stimulus changes 1 time unit after the rising edge.
// Backpressure: a responder process drives wready patterns and delayed bvalid.
module tb_dcache_wr_buffer;
  localparam int DEPTH = 2;
  localparam logic [3:0] AXI_ID = 4'd1;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } line_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dcache_wr_buffer_if bus();

  dcache_wr_buffer #(.DEPTH(DEPTH), .AXI_ID(AXI_ID)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  line_t       mq[$];
  bit          m_aw_done = 0;
  int          m_wbeat = 0;
  int          m_bursts = 0;
  int          m_pushes = 0;
  bit          hold_vld = 0;
  logic [31:0] held_data;
  logic [31:0] aw_log[$];
  logic [31:0] beat_log[$];
  bit          last_log[$];

  // responder knobs
  bit wp_mode = 0;
  int bdelay = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    bit h = 0;
    foreach (mq[i]) if (mq[i].addr[31:4] == a[31:4]) h = 1;
    return h;
  endfunction

  // Scoreboard: outputs must follow from the queue of accepted, not-yet-responded lines.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_aw_done = 0;
      m_wbeat = 0;
      hold_vld = 0;
    end else begin
      chk("wr_rdy", bus.wr_rdy, (mq.size() != DEPTH));
      chk("empty", bus.empty, (mq.size() == 0));
      chk("chk_hit", bus.chk_hit, model_hit(bus.chk_addr));
      if (bus.awvalid) begin
        chk("aw_has_line", (mq.size() != 0 && !m_aw_done), 1'b1);
        if (mq.size() != 0) chk("awaddr", bus.awaddr, {mq[0].addr[31:4], 4'h0});
        chk("aw_consts", {bus.awid, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot},
            {AXI_ID, 4'd3, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0});
      end
      if (bus.wvalid) begin
        chk("w_in_burst", (m_aw_done && m_wbeat < 4 && mq.size() != 0), 1'b1);
        if (mq.size() != 0 && m_wbeat < 4) chk("wdata", bus.wdata, mq[0].data[m_wbeat*32 +: 32]);
        chk("wlast", bus.wlast, (m_wbeat == 3));
        chk("w_consts", {bus.wid, bus.wstrb}, {AXI_ID, 4'hF});
        if (hold_vld) chk("w_stable", bus.wdata, held_data);
      end else begin
        chk("wlast_idle", bus.wlast, 1'b0);
      end
      if (bus.bready) chk("b_after_4", m_wbeat, 4);
      hold_vld = bus.wvalid && !bus.wready;
      held_data = bus.wdata;
      if (bus.awvalid && bus.awready) begin
        m_aw_done = 1;
        aw_log.push_back(bus.awaddr);
      end
      if (bus.wvalid && bus.wready) begin
        beat_log.push_back(bus.wdata);
        last_log.push_back(bus.wlast);
        m_wbeat++;
      end
      if (bus.bready && bus.bvalid && mq.size() != 0) begin
        void'(mq.pop_front());
        m_aw_done = 0;
        m_wbeat = 0;
        m_bursts++;
      end
      if (bus.wr_req && bus.wr_rdy) begin
        mq.push_back('{addr: bus.wr_addr, data: bus.wr_data});
        m_pushes++;
      end
    end
  end

  // AXI slave responder: wready pattern 1,0,0,1 when enabled; bvalid after bdelay cycles of bready.
  initial begin
    int ph = 0;
    int bcnt = 0;
    bus.wready = 1'b1;
    bus.bvalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      bus.wready = wp_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      if (bus.bready) bcnt++;
      else bcnt = 0;
      bus.bvalid = (bcnt >= bdelay);
    end
  end

  task automatic push_line(input logic [31:0] a, input logic [127:0] d);
    bit done = 0;
    bus.wr_req = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.wr_rdy) done = 1;
      @(posedge clk);
      #1;
    end
    bus.wr_req = 1'b0;
    if (!done) chk("push_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_empty(input int budget);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk);
      #1;
      if (bus.empty) done = 1;
    end
    if (!done) chk("empty_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    int p0;
    int wbudget;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.chk_addr = '0;
    bus.awready = 1'b1;
    bus.bid = 4'h7;
    bus.bresp = 2'b10;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awvalid", bus.awvalid, 1'b0);
    chk("rst_wvalid", bus.wvalid, 1'b0);
    chk("rst_bready", bus.bready, 1'b0);
    chk("rst_wlast", bus.wlast, 1'b0);
    chk("rst_wr_rdy", bus.wr_rdy, 1'b1);
    chk("rst_chk_hit", bus.chk_hit, 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single line, always-ready slave
    beat_log.delete();
    last_log.delete();
    push_line(32'h1FC0_0014, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("lat_n1_awvalid", bus.awvalid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_n2_awvalid", bus.awvalid, 1'b1);
    chk("lat_n2_awaddr", bus.awaddr, 32'h1FC0_0010);
    chk("lat_n2_awlen", bus.awlen, 4'd3);
    wait_empty(50);
    chk("single_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk("single_b0", beat_log[0], 32'h11);
      chk("single_b1", beat_log[1], 32'h22);
      chk("single_b2", beat_log[2], 32'h33);
      chk("single_b3", beat_log[3], 32'h44);
      chk("single_last", {last_log[0], last_log[1], last_log[2], last_log[3]}, 4'b0001);
    end
    chk("single_empty", bus.empty, 1'b1);

    // full with address channel stalled, plus hazard check
    bus.awready = 1'b0;
    p0 = m_pushes;
    b0 = m_bursts;
    push_line(32'h0000_1230, {4{32'hA5A5_0001}});
    push_line(32'h0000_5670, {4{32'hA5A5_0002}});
    chk("full_wr_rdy", bus.wr_rdy, 1'b0);
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_9990;
    repeat (3) @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    chk("full_push_cnt", m_pushes - p0, 2);
    chk("full_still_rdy0", bus.wr_rdy, 1'b0);
    bus.chk_addr = 32'h0000_123C;
    #1;
    chk("hazard_hit", bus.chk_hit, 1'b1);
    bus.chk_addr = 32'h0000_1240;
    #1;
    chk("hazard_miss", bus.chk_hit, 1'b0);
    bus.chk_addr = 32'h0000_123C;
    bus.awready = 1'b1;
    wait_empty(100);
    #1;
    chk("hazard_after_b", bus.chk_hit, 1'b0);
    chk("full_bursts", m_bursts - b0, 2);
    bus.chk_addr = '0;

    // wready backpressure
    wp_mode = 1;
    beat_log.delete();
    push_line(32'h0000_2000, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    wait_empty(100);
    wp_mode = 0;
    chk("bp_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk("bp_b0", beat_log[0], 32'hAAAA_0001);
      chk("bp_b1", beat_log[1], 32'hBBBB_0002);
      chk("bp_b2", beat_log[2], 32'hCCCC_0003);
      chk("bp_b3", beat_log[3], 32'hDDDD_0004);
    end

    // pointer wrap with delayed responses
    bdelay = 3;
    aw_log.delete();
    b0 = m_bursts;
    for (int i = 0; i < 5; i++) begin
      push_line(32'h0000_3000 + 32'(i * 16 + i), {4{32'(32'h5000_0000 + i)}});
    end
    wait_empty(300);
    chk("wrap_bursts", m_bursts - b0, 5);
    chk("wrap_aw_cnt", aw_log.size(), 5);
    if (aw_log.size() == 5) begin
      chk("wrap_aw0", aw_log[0], 32'h0000_3000);
      chk("wrap_aw1", aw_log[1], 32'h0000_3010);
      chk("wrap_aw2", aw_log[2], 32'h0000_3020);
      chk("wrap_aw3", aw_log[3], 32'h0000_3030);
      chk("wrap_aw4", aw_log[4], 32'h0000_3040);
    end
    bdelay = 0;

    // reset in the middle of a data burst
    push_line(32'h0000_4000, {4{32'h7777_0000}});
    push_line(32'h0000_4010, {4{32'h8888_0000}});
    wbudget = 0;
    while (m_wbeat < 1 && wbudget < 50) begin
      @(posedge clk);
      #2;
      wbudget++;
    end
    chk("midw_reached", (m_wbeat >= 1), 1'b1);
    reset = 1'b1;
    #1;
    chk("midw_wvalid", bus.wvalid, 1'b0);
    chk("midw_empty", bus.empty, 1'b1);
    chk("midw_wr_rdy", bus.wr_rdy, 1'b1);
    @(posedge clk);
    #1;
    chk("midw_wvalid_next", bus.wvalid, 1'b0);
    chk("midw_awvalid_next", bus.awvalid, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_empty", bus.empty, 1'b1);
    chk("post_rst_awvalid", bus.awvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
